// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
//   Shared TileLink-UL definitions for the SRAM responder slice:
//   field widths, A/D channel opcode encodings, responder FSM states and
//   small helpers for burst length and opcode classification.
// ---------------------------------------------------------------------------
package tl_pkg;

    localparam int unsigned ADDR_W   = 28;
    localparam int unsigned SOURCE_W = 5;
    localparam int unsigned SIZE_W   = 4;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned MASK_W   = 8;
    // Beat counter width; the largest supported burst is 8 beats.
    localparam int unsigned BEAT_W   = 4;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITH       = 3'd2;
    localparam logic [2:0] A_LOGIC       = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;
    localparam logic [2:0] A_HINT        = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_ACK,
        ST_GET
    } state_e;

    // Number of 64-bit beats carried by a transfer of 2**size bytes.
    function automatic logic [BEAT_W-1:0] beats(input logic [SIZE_W-1:0] size);
        if (size <= 4'd3) begin
            return BEAT_W'(1);
        end
        return BEAT_W'(1) << (size - 4'd3);
    endfunction

    function automatic logic is_put(input logic [2:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
    endfunction

    function automatic logic is_atomic(input logic [2:0] op);
        return (op == A_ARITH) || (op == A_LOGIC);
    endfunction

endpackage

// File: rtl/tl_sram_array.sv
// ---------------------------------------------------------------------------
// tl_sram_array
//   DEPTH x 64-bit storage built from flops. Cleared to zero by a synchronous
//   reset, one byte-masked write port, one combinational read port.
//
//   clk_i    clock
//   rst_i    synchronous active-high clear of every word
//   we_i     write enable
//   waddr_i  write word index
//   wmask_i  byte-lane write mask
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
// ---------------------------------------------------------------------------
module tl_sram_array
    import tl_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [MASK_W-1:0] wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int unsigned b = 0; b < MASK_W; b++) begin
                if (wmask_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tl_sram_responder.sv
// ---------------------------------------------------------------------------
// tl_sram_responder
//   TileLink-UL manager endpoint backed by a small byte-masked RAM. Serves
//   one transaction at a time: accepts A-channel requests (Put bursts, Get,
//   Hint, Arith/Logic), performs them on the local array and answers on the
//   D channel.
//
//   clock, reset                 single clock, synchronous active-high reset
//   auto_in_a_*                  A channel (request) from upstream
//   auto_in_d_*                  D channel (response) to upstream
//
//   Parameters
//     BASE_ADDR   byte base of the region (aligned to SIZE_BYTES)
//     SIZE_BYTES  region size in bytes, power of two, >= 64
//     MAX_SIZE    largest supported lg2 transfer size
// ---------------------------------------------------------------------------
module tl_sram_responder
    import tl_pkg::*;
#(
    parameter logic [27:0] BASE_ADDR  = 28'h0000000,
    parameter int unsigned SIZE_BYTES = 512,
    parameter int unsigned MAX_SIZE   = 6
) (
    input  logic                clock,
    input  logic                reset,

    output logic                auto_in_a_ready,
    input  logic                auto_in_a_valid,
    input  logic [2:0]          auto_in_a_bits_opcode,
    input  logic [SIZE_W-1:0]   auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0] auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]   auto_in_a_bits_address,
    input  logic [MASK_W-1:0]   auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]   auto_in_a_bits_data,

    input  logic                auto_in_d_ready,
    output logic                auto_in_d_valid,
    output logic [2:0]          auto_in_d_bits_opcode,
    output logic [1:0]          auto_in_d_bits_param,
    output logic [SIZE_W-1:0]   auto_in_d_bits_size,
    output logic [SOURCE_W-1:0] auto_in_d_bits_source,
    output logic                auto_in_d_bits_sink,
    output logic                auto_in_d_bits_denied,
    output logic [DATA_W-1:0]   auto_in_d_bits_data,
    output logic                auto_in_d_bits_corrupt
);

    localparam int unsigned DEPTH = SIZE_BYTES / 8;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    // One extra bit so BASE_ADDR + SIZE_BYTES cannot overflow at the top
    // of the address space.
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(SIZE_BYTES);

    // ------------------------------------------------------------------
    // Registered transaction context
    // ------------------------------------------------------------------
    state_e              state_q,   state_d;
    logic [2:0]          op_q,      op_d;
    logic [SIZE_W-1:0]   size_q,    size_d;
    logic [SOURCE_W-1:0] source_q,  source_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic                inrange_q, inrange_d;
    logic [BEAT_W-1:0]   beat_q,    beat_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] a_offset;
    logic [IDX_W-1:0]  a_idx;
    logic              a_inrange;
    logic              a_fire;
    logic              d_fire;
    logic [BEAT_W-1:0] last_beat;
    logic              denied;
    logic [IDX_W-1:0]  cur_idx;
    logic              unused_offset_bits;

    assign a_offset  = auto_in_a_bits_address - BASE_ADDR;
    assign a_idx     = a_offset[IDX_W+2:3];
    assign a_inrange = ({1'b0, auto_in_a_bits_address} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, auto_in_a_bits_address} <  LIMIT);
    // Byte-offset and above-region bits carry no word index information.
    assign unused_offset_bits = ^{a_offset[2:0], a_offset[ADDR_W-1:IDX_W+3]};

    assign a_fire    = auto_in_a_valid && auto_in_a_ready;
    assign d_fire    = auto_in_d_valid && auto_in_d_ready;
    assign last_beat = beats(size_q) - BEAT_W'(1);
    assign cur_idx   = idx_q + IDX_W'(beat_q);

    // Hints are always acknowledged; Arith/Logic are not supported here.
    assign denied = (op_q != A_HINT) && (!inrange_q || is_atomic(op_q));

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_rdata;

    tl_sram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wmask_i (auto_in_a_bits_mask),
        .wdata_i (auto_in_a_bits_data),
        .raddr_i (cur_idx),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            size_q    <= '0;
            source_q  <= '0;
            idx_q     <= '0;
            inrange_q <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            size_q    <= size_d;
            source_q  <= source_d;
            idx_q     <= idx_d;
            inrange_q <= inrange_d;
            beat_q    <= beat_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        size_d    = size_q;
        source_d  = source_q;
        idx_d     = idx_q;
        inrange_d = inrange_q;
        beat_d    = beat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    op_d      = auto_in_a_bits_opcode;
                    size_d    = auto_in_a_bits_size;
                    source_d  = auto_in_a_bits_source;
                    idx_d     = a_idx;
                    inrange_d = a_inrange;
                    beat_d    = '0;
                    if (auto_in_a_bits_opcode == A_GET) begin
                        state_d = ST_GET;
                    end else if (auto_in_a_bits_opcode == A_HINT) begin
                        state_d = ST_ACK;
                    end else if (beats(auto_in_a_bits_size) > BEAT_W'(1)) begin
                        // Beat 0 is consumed on this fire.
                        state_d = ST_PUT;
                        beat_d  = BEAT_W'(1);
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_PUT: begin
                if (a_fire) begin
                    if (beat_q == last_beat) begin
                        state_d = ST_ACK;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_ACK: begin
                if (d_fire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET: begin
                if (d_fire) begin
                    if (beat_q == last_beat) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and RAM write port
    // ------------------------------------------------------------------
    always_comb begin
        auto_in_a_ready        = 1'b0;
        auto_in_d_valid        = 1'b0;
        auto_in_d_bits_opcode  = '0;
        auto_in_d_bits_param   = '0;
        auto_in_d_bits_size    = '0;
        auto_in_d_bits_source  = '0;
        auto_in_d_bits_sink    = 1'b0;
        auto_in_d_bits_denied  = 1'b0;
        auto_in_d_bits_data    = '0;
        auto_in_d_bits_corrupt = 1'b0;
        ram_we                 = 1'b0;
        ram_waddr              = cur_idx;

        unique case (state_q)
            ST_IDLE: begin
                auto_in_a_ready = 1'b1;
                ram_we          = a_fire && is_put(auto_in_a_bits_opcode) && a_inrange;
                ram_waddr       = a_idx;
            end
            ST_PUT: begin
                // Later beats use the first beat's range check and index.
                auto_in_a_ready = 1'b1;
                ram_we          = a_fire && is_put(op_q) && inrange_q;
                ram_waddr       = cur_idx;
            end
            ST_ACK: begin
                auto_in_d_valid       = 1'b1;
                auto_in_d_bits_opcode = (op_q == A_HINT) ? D_HINT_ACK : D_ACCESS_ACK;
                auto_in_d_bits_size   = size_q;
                auto_in_d_bits_source = source_q;
                auto_in_d_bits_denied = denied;
            end
            ST_GET: begin
                auto_in_d_valid        = 1'b1;
                auto_in_d_bits_opcode  = D_ACCESS_ACK_DATA;
                auto_in_d_bits_size    = size_q;
                auto_in_d_bits_source  = source_q;
                auto_in_d_bits_denied  = denied;
                auto_in_d_bits_data    = denied ? '0 : ram_rdata;
                auto_in_d_bits_corrupt = denied;
            end
            default: ;
        endcase
    end

    // Opcodes 6/7 and oversize transfers are outside the supported protocol.
    a_request_legal: assert property (
        @(posedge clock) disable iff (reset)
        a_fire |-> ((auto_in_a_bits_opcode <= A_HINT) &&
                    (auto_in_a_bits_size <= SIZE_W'(MAX_SIZE)))
    );

endmodule

// File: tb/tb_tl_sram_responder.sv
module tb_tl_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [3:0]  a_size;
    logic [4:0]  a_source;
    logic [27:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [4:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    tl_sram_responder #(
        .BASE_ADDR  (28'h0000000),
        .SIZE_BYTES (512),
        .MAX_SIZE   (6)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one A beat and return just after the edge on which it fired.
    task automatic a_send(input string tag, input logic [2:0] op, input logic [3:0] sz,
                          input logic [4:0] src, input logic [27:0] addr,
                          input logic [7:0] mask, input logic [63:0] data);
        int unsigned cnt = 0;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        while (!a_ready && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq({tag, ".a_ready"}, 64'(a_ready), 64'd1);
        tick();
        a_valid = 1'b0;
    endtask

    // Wait for a D beat, check every field, then take it.
    task automatic d_expect(input string tag, input logic [2:0] op, input logic [3:0] sz,
                            input logic [4:0] src, input logic den, input logic cor,
                            input logic [63:0] data);
        int unsigned cnt = 0;
        while (!d_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        check_eq({tag, ".d_valid"},   64'(d_valid),   64'd1);
        check_eq({tag, ".opcode"},    64'(d_opcode),  64'(op));
        check_eq({tag, ".param"},     64'(d_param),   64'd0);
        check_eq({tag, ".size"},      64'(d_size),    64'(sz));
        check_eq({tag, ".source"},    64'(d_source),  64'(src));
        check_eq({tag, ".sink"},      64'(d_sink),    64'd0);
        check_eq({tag, ".denied"},    64'(d_denied),  64'(den));
        check_eq({tag, ".corrupt"},   64'(d_corrupt), 64'(cor));
        check_eq({tag, ".data"},      d_data,         data);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
    endtask

    // Single-beat write-class request: ack must be valid one cycle after the fire.
    task automatic put_single(input string tag, input logic [2:0] op, input logic [27:0] addr,
                              input logic [7:0] mask, input logic [63:0] data,
                              input logic [4:0] src, input logic den);
        a_send(tag, op, 4'd3, src, addr, mask, data);
        check_eq({tag, ".ack_lat"}, 64'(d_valid), 64'd1);
        check_eq({tag, ".a_ready_low"}, 64'(a_ready), 64'd0);
        d_expect(tag, 3'd0, 4'd3, src, den, 1'b0, 64'd0);
    endtask

    // Single-beat Get: data at t+1, next A acceptable at t+2.
    task automatic get_single(input string tag, input logic [27:0] addr, input logic [63:0] exp);
        a_send(tag, 3'd4, 4'd3, 5'd3, addr, 8'hFF, 64'd0);
        check_eq({tag, ".data_lat"}, 64'(d_valid), 64'd1);
        d_expect(tag, 3'd1, 4'd3, 5'd3, 1'b0, 1'b0, exp);
        check_eq({tag, ".next_a_ready"}, 64'(a_ready), 64'd1);
    endtask

    initial begin
        reset     = 1'b1;
        a_valid   = 1'b0;
        a_opcode  = '0;
        a_size    = '0;
        a_source  = '0;
        a_address = '0;
        a_mask    = '0;
        a_data    = '0;
        d_ready   = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst.d_valid", 64'(d_valid),  64'd0);
        check_eq("rst.opcode",  64'(d_opcode), 64'd0);
        check_eq("rst.size",    64'(d_size),   64'd0);
        check_eq("rst.source",  64'(d_source), 64'd0);
        check_eq("rst.data",    d_data,        64'd0);
        check_eq("rst.denied",  64'(d_denied), 64'd0);
        check_eq("rst.corrupt", 64'(d_corrupt), 64'd0);
        reset = 1'b0;
        tick();
        check_eq("rst.a_ready", 64'(a_ready), 64'd1);

        // Full write then read back
        put_single("putfull", 3'd0, 28'h10, 8'hFF, 64'h1122334455667788, 5'd7, 1'b0);
        get_single("get_full", 28'h10, 64'h1122334455667788);

        // Partial write merges low four bytes
        put_single("putpart", 3'd1, 28'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 5'd4, 1'b0);
        get_single("get_part", 28'h10, 64'h11223344_BBBBBBBB);

        // 8-beat Put burst; later beat addresses are junk and must be ignored
        a_valid   = 1'b1;
        a_opcode  = 3'd0;
        a_size    = 4'd6;
        a_source  = 5'd9;
        a_address = 28'h40;
        a_mask    = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            a_data = 64'(i);
            if (i > 0) a_address = 28'hFFFFFC0;
            check_eq("pburst.a_ready", 64'(a_ready), 64'd1);
            check_eq("pburst.no_early_ack", 64'(d_valid), 64'd0);
            tick();
        end
        a_valid = 1'b0;
        check_eq("pburst.ack_lat", 64'(d_valid), 64'd1);
        d_expect("pburst.ack", 3'd0, 4'd6, 5'd9, 1'b0, 1'b0, 64'd0);
        check_eq("pburst.single_ack", 64'(d_valid), 64'd0);
        tick();
        check_eq("pburst.single_ack2", 64'(d_valid), 64'd0);

        // 8-beat Get burst with d_ready low every other cycle
        a_send("gburst", 3'd4, 4'd6, 5'd11, 28'h40, 8'hFF, 64'd0);
        for (int i = 0; i < 8; i++) begin
            d_ready = 1'b0;
            check_eq("gburst.d_valid", 64'(d_valid), 64'd1);
            check_eq("gburst.opcode",  64'(d_opcode), 64'd1);
            check_eq("gburst.data",    d_data, 64'(i));
            check_eq("gburst.a_ready_low", 64'(a_ready), 64'd0);
            tick();
            check_eq("gburst.stall_data",   d_data, 64'(i));
            check_eq("gburst.stall_source", 64'(d_source), 64'd11);
            check_eq("gburst.stall_size",   64'(d_size), 64'd6);
            d_ready = 1'b1;
            tick();
        end
        d_ready = 1'b0;
        check_eq("gburst.done_valid", 64'(d_valid), 64'd0);
        check_eq("gburst.done_a_ready", 64'(a_ready), 64'd1);

        // Out-of-range Get, size 4: two denied, corrupt beats with zero data
        a_send("oor_get", 3'd4, 4'd4, 5'd2, 28'h200, 8'hFF, 64'd0);
        d_expect("oor_get.b0", 3'd1, 4'd4, 5'd2, 1'b1, 1'b1, 64'd0);
        d_expect("oor_get.b1", 3'd1, 4'd4, 5'd2, 1'b1, 1'b1, 64'd0);
        check_eq("oor_get.done", 64'(d_valid), 64'd0);

        // Out-of-range Put is denied and must not alias onto word 0
        put_single("oor_put", 3'd0, 28'h200, 8'hFF, 64'hDEADBEEFCAFEF00D, 5'd5, 1'b0 | 1'b1);
        get_single("oor_put.word0", 28'h0, 64'd0);

        // Arith at a valid address: denied, no write
        put_single("arith", 3'd2, 28'h10, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 5'd6, 1'b1);
        get_single("arith.unchanged", 28'h10, 64'h11223344_BBBBBBBB);

        // Hint: HintAck, never denied
        a_send("hint", 3'd5, 4'd3, 5'd8, 28'h18, 8'hFF, 64'd0);
        check_eq("hint.ack_lat", 64'(d_valid), 64'd1);
        d_expect("hint", 3'd2, 4'd3, 5'd8, 1'b0, 1'b0, 64'd0);

        // Reset in the middle of a Get burst at beat 3
        a_send("rst_get", 3'd4, 4'd6, 5'd12, 28'h40, 8'hFF, 64'd0);
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_get.data", d_data, 64'(i));
            tick();
        end
        d_ready = 1'b0;
        check_eq("rst_get.beat3", d_data, 64'd3);
        reset = 1'b1;
        tick();
        check_eq("rst_get.d_valid", 64'(d_valid), 64'd0);
        reset = 1'b0;
        check_eq("rst_get.a_ready", 64'(a_ready), 64'd1);
        tick();
        check_eq("rst_get.no_beat", 64'(d_valid), 64'd0);
        get_single("rst_get.cleared40", 28'h40, 64'd0);
        get_single("rst_get.cleared10", 28'h10, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
